// File: rtl/pc_sequencer_if.sv
// Control inputs from decode/ALU and fetch-side outputs of the program-counter stage.
// The sequencer connects through the slave modport; its driver uses master.
interface pc_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             halt;
    logic             branch;
    logic             zero;
    logic [15:0]      imm16;
    logic             jump;
    logic [25:0]      jump_target;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_valid;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output stall, halt, branch, zero, imm16, jump, jump_target,
        input  pc, pc_plus4, fetch_valid, halted, instr_count
    );

    modport slave (
        input  stall, halt, branch, zero, imm16, jump, jump_target,
        output pc, pc_plus4, fetch_valid, halted, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the fetch PC, selects sequential/branch/jump flow,
// sequences BOOT -> RUN -> HALTED and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic          clk,
    input  logic          areset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pc_plus4;
    logic [31:0]      branch_off;
    logic [31:0]      branch_pc;
    logic [31:0]      jump_pc;
    logic             retire;
    logic             fetch_valid;
    logic             halted;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: purely from registered state, so no input reaches
    // fetch_valid or halted combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        fetch_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            RUN:     fetch_valid = 1'b1;
            HALTED:  halted      = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC datapath (all adds wrap modulo 2^32)
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        branch_pc  = pc_plus4 + branch_off;
        jump_pc    = {pc_plus4[31:28], bus.jump_target, 2'b00};
    end

    // An instruction retires on a RUN edge that is neither stalled nor a halt.
    assign retire = (state_q == RUN) && !bus.halt && !bus.stall;

    always_comb begin
        pc_d = pc_q;
        if (retire) begin
            if (bus.jump) begin
                pc_d = jump_pc;
            end else if (bus.branch && bus.zero) begin
                pc_d = branch_pc;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // Saturating retired-instruction counter.
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.halted      = halted;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, multi-cycle corner
// sequences (async reset, halt+stall, wrap, saturation) and a randomized model comparison.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
    localparam int          SAT_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset;
    logic w_areset;
    logic s_areset;

    pc_sequencer_if #(.CNT_W(32))    u_if ();
    pc_sequencer_if #(.CNT_W(32))    w_if ();
    pc_sequencer_if #(.CNT_W(SAT_W)) s_if ();

    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) u_dut (
        .clk(clk), .areset(areset), .bus(u_if.slave)
    );
    pc_sequencer #(.RESET_PC(WRAP_PC), .CNT_W(32)) w_dut (
        .clk(clk), .areset(w_areset), .bus(w_if.slave)
    );
    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(SAT_W)) s_dut (
        .clk(clk), .areset(s_areset), .bus(s_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        st, hl, br, zr, jp;
        logic [15:0] im;
        logic [25:0] jt;
        logic [31:0] e_pc;
        logic        e_fv, e_hl;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model state (main DUT)
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_boot;
    bit          m_halted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [31:0] e_pc, input logic e_fv,
                              input logic e_hl, input logic [31:0] e_cnt);
        check({tag, ".pc"},          64'(u_if.pc),          64'(e_pc));
        check({tag, ".pc_plus4"},    64'(u_if.pc_plus4),    64'(e_pc + 32'd4));
        check({tag, ".fetch_valid"}, 64'(u_if.fetch_valid), 64'(e_fv));
        check({tag, ".halted"},      64'(u_if.halted),      64'(e_hl));
        check({tag, ".instr_count"}, 64'(u_if.instr_count), 64'(e_cnt));
    endtask

    task automatic drive(input logic st, input logic hl, input logic br, input logic zr,
                         input logic [15:0] im, input logic jp, input logic [25:0] jt);
        u_if.stall       = st;
        u_if.halt        = hl;
        u_if.branch      = br;
        u_if.zero        = zr;
        u_if.imm16       = im;
        u_if.jump        = jp;
        u_if.jump_target = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across an edge, check reset values, release 1ns after an edge.
    task automatic reset_main(input string tag);
        areset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        check_main({tag, ".rst"}, RST_PC, 1'b0, 1'b0, 32'd0);
        areset = 1'b1;
        #2;
        check_main({tag, ".boot"}, RST_PC, 1'b0, 1'b0, 32'd0);
        m_pc     = RST_PC;
        m_cnt    = 32'd0;
        m_boot   = 1'b1;
        m_halted = 1'b0;
    endtask

    // Behavioural next-state rules: one call per rising edge.
    task automatic model_step(input logic st, input logic hl, input logic br, input logic zr,
                              input logic [15:0] im, input logic jp, input logic [25:0] jt);
        int off;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (hl) begin
            m_halted = 1'b1;
        end else if (!st) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (jp) begin
                m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
            end else if (br && zr) begin
                off  = int'($signed(im)) * 4;
                m_pc = m_pc + 32'd4 + 32'(off);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic vec_t mk(logic st, logic hl, logic br, logic zr, logic [15:0] im,
                                logic jp, logic [25:0] jt, logic [31:0] e_pc,
                                logic e_fv, logic e_hl, logic [31:0] e_cnt);
        vec_t v;
        v.st = st; v.hl = hl; v.br = br; v.zr = zr; v.im = im; v.jp = jp; v.jt = jt;
        v.e_pc = e_pc; v.e_fv = e_fv; v.e_hl = e_hl; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset   = 1'b0;
        w_areset = 1'b0;
        s_areset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        w_if.stall = 1'b0; w_if.halt = 1'b0; w_if.branch = 1'b0; w_if.zero = 1'b0;
        w_if.imm16 = 16'h0; w_if.jump = 1'b0; w_if.jump_target = 26'h0;
        s_if.stall = 1'b0; s_if.halt = 1'b0; s_if.branch = 1'b0; s_if.zero = 1'b0;
        s_if.imm16 = 16'h0; s_if.jump = 1'b0; s_if.jump_target = 26'h0;

        //              st   hl   br   zr   imm16     jp   target       pc            fv   hl   cnt
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,16'h0004,1'b1,26'h3FF_FFFF,32'h0040_0000,1'b1,1'b0,32'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_0004,1'b1,1'b0,32'd1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_0008,1'b1,1'b0,32'd2));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_000C,1'b1,1'b0,32'd3));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_000C,1'b1,1'b0,32'd3));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,16'h0020,1'b1,26'h000_0040,32'h0040_000C,1'b1,1'b0,32'd3));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_000C,1'b1,1'b0,32'd3));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_0010,1'b1,1'b0,32'd4));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'hFFFC,1'b0,26'h000_0000,32'h0040_0004,1'b1,1'b0,32'd5));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_0008,1'b1,1'b0,32'd6));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_000C,1'b1,1'b0,32'd7));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0040_0010,1'b1,1'b0,32'd8));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'hFFFC,1'b0,26'h000_0000,32'h0040_0014,1'b1,1'b0,32'd9));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'hFFFC,1'b0,26'h000_0000,32'h0040_0008,1'b1,1'b0,32'd10));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'h0010,1'b1,26'h000_0040,32'h0000_0100,1'b1,1'b0,32'd11));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0000_0104,1'b1,1'b0,32'd12));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,26'h000_0108,32'h0000_0420,1'b1,1'b0,32'd13));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,16'h0008,1'b0,26'h000_0000,32'h0000_0420,1'b0,1'b1,32'd13));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,26'h000_0040,32'h0000_0420,1'b0,1'b1,32'd13));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'h0005,1'b0,26'h000_0000,32'h0000_0420,1'b0,1'b1,32'd13));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0000_0420,1'b0,1'b1,32'd13));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,32'h0000_0420,1'b0,1'b1,32'd13));

        // ---------------- directed vector table ----------------
        reset_main("tab");
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].hl, vecs[i].br, vecs[i].zr, vecs[i].im, vecs[i].jp, vecs[i].jt);
            tick();
            check_main($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_hl, vecs[i].e_cnt);
        end

        // ---------------- async reset mid-cycle while HALTED ----------------
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 26'h000_0040);
        #2;
        areset = 1'b0;
        #1;
        check_main("async_rst", RST_PC, 1'b0, 1'b0, 32'd0);
        #1;
        areset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

        // ---------------- halt together with stall ----------------
        reset_main("hs");
        tick();
        check_main("hs.boot_edge", RST_PC, 1'b1, 1'b0, 32'd0);
        tick();
        check_main("hs.run1", RST_PC + 32'd4, 1'b1, 1'b0, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        check_main("hs.halt", RST_PC + 32'd4, 1'b0, 1'b1, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        tick();
        check_main("hs.frozen", RST_PC + 32'd4, 1'b0, 1'b1, 32'd1);

        // ---------------- wrap with RESET_PC = 0xFFFF_FFFC ----------------
        check("wrap.rst_pc",       64'(w_if.pc),       64'(WRAP_PC));
        check("wrap.rst_pc_plus4", 64'(w_if.pc_plus4), 64'd0);
        w_areset = 1'b1;
        tick();
        check("wrap.boot_pc", 64'(w_if.pc), 64'(WRAP_PC));
        check("wrap.boot_fv", 64'(w_if.fetch_valid), 64'd1);
        tick();
        check("wrap.seq_pc", 64'(w_if.pc), 64'd0);
        w_if.branch = 1'b1; w_if.zero = 1'b1; w_if.imm16 = 16'hFFFE;
        tick();
        check("wrap.neg_branch_pc", 64'(w_if.pc), 64'(WRAP_PC));
        check("wrap.neg_branch_p4", 64'(w_if.pc_plus4), 64'd0);
        w_if.branch = 1'b0; w_if.zero = 1'b0; w_if.imm16 = 16'h0;

        // ---------------- counter saturation on narrow counter ----------------
        s_areset = 1'b1;
        tick();
        check("sat.boot_cnt", 64'(s_if.instr_count), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("sat.cnt%0d", i), 64'(s_if.instr_count),
                  64'((i > 7) ? 7 : i));
        end

        // ---------------- randomized vs reference model ----------------
        for (int r = 0; r < 4; r++) begin
            reset_main($sformatf("rnd%0d", r));
            for (int c = 0; c < 500; c++) begin
                logic        st, hl, br, zr, jp;
                logic [15:0] im;
                logic [25:0] jt;
                st = ($urandom_range(0, 3) == 0);
                hl = ($urandom_range(0, 149) == 0);
                br = $urandom_range(0, 1) == 1;
                zr = $urandom_range(0, 1) == 1;
                jp = ($urandom_range(0, 3) == 0);
                im = 16'($urandom);
                jt = 26'($urandom);
                drive(st, hl, br, zr, im, jp, jt);
                model_step(st, hl, br, zr, im, jp, jt);
                tick();
                check_main($sformatf("rnd%0d.c%0d", r, c), m_pc,
                           !m_boot && !m_halted, m_halted, m_cnt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle processor.
- Holds the 32-bit PC and computes next-PC for sequential, branch and jump flow. Drives the fetch address into instruction memory.
- Sequences boot and halt, supports pipeline-freeze stalls, and keeps a retired-instruction counter.
- Sits directly upstream of instruction fetch and the register-file datapath. Consumes branch/jump decisions from decode/ALU in the same cycle.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset. Bits [1:0] must be 2'b00.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- areset  input  1  asynchronous, active-low reset.
- stall  input  1  freeze PC and counter this cycle.
- halt  input  1  current instruction is a halt; enter HALTED.
- branch  input  1  current instruction is a conditional branch.
- zero  input  1  ALU zero flag; branch is taken when branch & zero.
- imm16  input  16  branch offset in words, signed.
- jump  input  1  current instruction is a jump.
- jump_target  input  26  jump word index.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- halted  output  1  sequencer is in HALTED.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: areset low at any time, including mid-operation, immediately forces:
  - pc = RESET_PC
  - state = BOOT
  - fetch_valid = 0
  - halted = 0
  - instr_count = 0
- Reset release is sampled on the next rising edge.
- States:
  - BOOT: lasts exactly one clock after reset release. pc holds RESET_PC, fetch_valid = 0, all control inputs ignored. Next state is RUN.
  - RUN: fetch_valid = 1. Next pc selected by priority halt > stall > jump > taken branch > sequential.
  - HALTED: terminal until reset. pc frozen, fetch_valid = 0, halted = 1, all inputs ignored.
- Next-pc in RUN (registered, takes effect the edge after the decision):
  - halt: pc holds, state becomes HALTED, counter does not increment.
  - stall (no halt): pc holds, counter holds, state stays RUN.
  - jump: pc = {pc_plus4[31:28], jump_target, 2'b00}.
  - branch & zero: pc = pc_plus4 + (sign_extend(imm16) << 2), modulo 2^32.
  - branch & !zero, or no control input: pc = pc_plus4.
- Jump and branch asserted together: jump wins.
- Arithmetic:
  - All adds are 32-bit and wrap silently (32'hFFFF_FFFC + 4 = 0).
  - pc[1:0] is always 2'b00.
  - Negative offsets use two's complement sign extension of imm16[15].
- instr_count:
  - Increments by 1 on each RUN edge where neither stall nor halt is asserted.
  - Saturates at all-ones; never wraps.
- halted is registered; it asserts on the edge that enters HALTED.
- No combinational path from inputs to pc, fetch_valid or halted. pc_plus4 depends only on pc.

Test Plan:
- Reset, release, 4 idle cycles -> cycle 1: pc = 32'h0040_0000, fetch_valid = 0 (BOOT). Then pc = 0040_0000, 0040_0004, 0040_0008; instr_count = 3 after three RUN edges.
- At pc = 32'h0040_0010: branch = 1, zero = 1, imm16 = 16'hFFFC -> next pc = 32'h0040_0004. Same with zero = 0 -> next pc = 32'h0040_0014.
- At pc = 32'h0040_0008: jump = 1 and branch = 1, zero = 1, jump_target = 26'h000_0040 -> next pc = 32'h0000_0100 (jump priority).
- stall held 3 cycles at pc = 32'h0040_000C -> pc and instr_count unchanged for 3 edges, then resume at 32'h0040_0010. halt asserted together with stall -> HALTED entered.
- halt at pc = 32'h0040_0020 -> next edge halted = 1, fetch_valid = 0, pc stays 32'h0040_0020. Later jump/branch inputs are ignored. areset pulsed low mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.
- Wrap: force pc to 32'hFFFF_FFFC via RESET_PC override -> pc_plus4 = 0, and the next sequential pc = 32'h0000_0000.
